mod_add_ctrl: RTL

Sequencer for modular addition and subtraction of 1027-bit operands. It drives the start/done handshake of the team's multi-cycle 1027-bit adder/subtractor (`adder_cycle`) as its initiator, issuing one to three adder passes per operation. It returns (A ± B) mod M to the exponentiation datapath.

---
 rtl/mod_add_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mod_add_ctrl.sv
`timescale 1ns/1ps
// mod_add_ctrl
// Sequences one to three passes of the external 1027-bit adder/subtractor to
// produce (A + B) mod M or (A - B) mod M, given 0 < M, A < M, B < M.
//
// Ports
//   clk, resetn        : clock, synchronous active-low reset
//   start, op_sub      : request (accepted only while idle) and operation select
//   in_a, in_b, in_m   : operands, sampled with start
//   result, done       : modular result, valid in the one-cycle done pulse and held
//   busy               : high from the cycle after acceptance through done
//   add_start          : adder start pulse
//   add_subtract       : adder mode (1 = a - b)
//   add_in_a, add_in_b : adder operands, held from issue through add_done
//   add_result         : adder result, bit 1027 is the sign of a subtraction
//   add_done           : adder completion pulse
module mod_add_ctrl (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          op_sub,
  input  logic [1026:0] in_a,
  input  logic [1026:0] in_b,
  input  logic [1026:0] in_m,
  output logic [1026:0] result,
  output logic          done,
  output logic          busy,
  output logic          add_start,
  output logic          add_subtract,
  output logic [1026:0] add_in_a,
  output logic [1026:0] add_in_b,
  input  logic [1027:0] add_result,
  input  logic          add_done
);

  localparam int unsigned W = 1027;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [W-1:0]   m_r;
  logic           sub_r;
  logic [1:0]     pass;     // pass in flight, 1..3; 0 when idle
  logic           branch;   // the sign-deciding pass came out negative

  logic           accept;
  logic           pass_end;
  logic           res_neg;
  logic           decide_pass;
  logic           last_pass;

  assign accept   = (state == S_IDLE) && start;
  assign pass_end = (state == S_WAIT) && add_done;
  assign res_neg  = add_result[W];

  // The sign-deciding pass is A - D for addition (pass 2) and A - B for
  // subtraction (pass 1); a non-negative result there is already the answer.
  assign decide_pass = sub_r ? (pass == 2'd1) : (pass == 2'd2);
  assign last_pass   = (pass == 2'd3) || (!branch && decide_pass && !res_neg);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (add_done) state_nxt = last_pass ? S_DONE : S_ISSUE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    add_start = (state == S_ISSUE);
    done      = (state == S_DONE);
    busy      = (state != S_IDLE);
  end

  // Operand / pass bookkeeping. Adder operands for the next pass are loaded
  // on the edge that enters ISSUE, so they are stable for the whole pass.
  // Intermediate D never needs its own register: it goes straight into add_in_b.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_r          <= '0;
      b_r          <= '0;
      m_r          <= '0;
      sub_r        <= 1'b0;
      pass         <= '0;
      branch       <= 1'b0;
      result       <= '0;
      add_subtract <= 1'b0;
      add_in_a     <= '0;
      add_in_b     <= '0;
    end else if (accept) begin
      a_r          <= in_a;
      b_r          <= in_b;
      m_r          <= in_m;
      sub_r        <= op_sub;
      pass         <= 2'd1;
      branch       <= 1'b0;
      // P1 is M - B for addition, A - B for subtraction
      add_subtract <= 1'b1;
      add_in_a     <= op_sub ? in_a : in_m;
      add_in_b     <= in_b;
    end else if (pass_end) begin
      if (last_pass) begin
        result <= add_result[W-1:0];
        pass   <= '0;
      end else begin
        pass <= pass + 2'd1;
        if (decide_pass && res_neg) begin
          branch <= 1'b1;
        end
        case ({sub_r, pass})
          3'b0_01: begin  // add: D ready, next A - D
            add_subtract <= 1'b1;
            add_in_a     <= a_r;
            add_in_b     <= add_result[W-1:0];
          end
          3'b0_10: begin  // add: A - D negative, next A + B
            add_subtract <= 1'b0;
            add_in_a     <= a_r;
            add_in_b     <= b_r;
          end
          3'b1_01: begin  // sub: A - B negative, next M - B
            add_subtract <= 1'b1;
            add_in_a     <= m_r;
            add_in_b     <= b_r;
          end
          default: begin  // sub: D ready, next A + D
            add_subtract <= 1'b0;
            add_in_a     <= a_r;
            add_in_b     <= add_result[W-1:0];
          end
        endcase
      end
    end
  end

endmodule
